// File: rtl/button_event_logger_if.sv
// Avalon-MM write-only bus from the button event logger to the log RAM.
`timescale 1ns/1ps
interface button_event_logger_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [3:0]            mem_byteenable;
  logic [31:0]           mem_writedata;

  modport master (output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata);
  modport slave  (input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata);
endinterface

// File: rtl/button_event_logger.sv
// Debounces active-low buttons, timestamps every debounced change and writes the
// resulting event words as a circular log into an Avalon-MM RAM through a small FIFO.
`timescale 1ns/1ps
module button_event_logger #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000,
  parameter int ADDR_WIDTH      = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  input  logic                   enable,
  input  logic                   clear,
  button_event_logger_if.master  mem,
  output logic [ADDR_WIDTH-1:0]  wr_ptr,
  output logic                   wrapped,
  output logic                   overflow
);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W  = $clog2(TICK_DIV + 1);
  localparam int FIDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_e;

  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d, stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0]       db_cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       db_cnt_d [NUM_BUTTONS];
  logic [DIV_W-1:0]       div_q, div_d;
  logic [23:0]            ts_q, ts_d;
  logic [31:0]            fifo_mem_q [FIFO_DEPTH];
  logic [31:0]            fifo_mem_d [FIFO_DEPTH];
  logic [FIDX_W-1:0]      fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [FCNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic                   overflow_q, overflow_d;

  logic [NUM_BUTTONS-1:0] sync_s, changed_s;
  logic [3:0]             changed4_s, stable4_s;
  logic [31:0]            event_word_s;
  logic                   push_s, pop_s, accept_s, fifo_full_s, fifo_empty_s;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q, wr_ptr_q;
  logic                   cs_q, we_q, wrapped_q;
  logic [3:0]             be_q;
  logic [31:0]            wdata_q;

  // Next-state logic for synchroniser, debounce, timestamp, event detection and FIFO.
  always_comb begin
    sync1_d       = buttons_n;
    sync2_d       = sync1_q;
    sync_s        = ~sync2_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sync_s[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_LAST) begin
        db_cnt_d[i] = '0;
        stable_d[i] = sync_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end

    if (clear) begin
      div_d = '0;
      ts_d  = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      ts_d  = ts_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
      ts_d  = ts_q;
    end

    changed_s  = stable_q ^ stable_prev_q;
    changed4_s = 4'h0;
    stable4_s  = 4'h0;
    changed4_s[NUM_BUTTONS-1:0] = changed_s;
    stable4_s[NUM_BUTTONS-1:0]  = stable_q;
    event_word_s = {ts_q, changed4_s, stable4_s};

    // A full FIFO still accepts a push when the writer pops in the same cycle.
    fifo_full_s  = (fifo_cnt_q == FCNT_FULL);
    fifo_empty_s = (fifo_cnt_q == '0);
    push_s       = (|changed_s) && enable && !clear;
    pop_s        = (state_q == ST_IDLE) && !fifo_empty_s && !clear;
    accept_s     = push_s && (!fifo_full_s || pop_s);

    fifo_mem_d = fifo_mem_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept_s) begin
        fifo_mem_d[fifo_wr_q] = event_word_s;
        fifo_wr_d = (fifo_wr_q == FIDX_LAST) ? '0 : fifo_wr_q + 1'b1;
      end else begin
        fifo_wr_d = fifo_wr_q;
      end
      if (pop_s) begin
        fifo_rd_d = (fifo_rd_q == FIDX_LAST) ? '0 : fifo_rd_q + 1'b1;
      end else begin
        fifo_rd_d = fifo_rd_q;
      end
      if (accept_s && !pop_s) begin
        fifo_cnt_d = fifo_cnt_q + 1'b1;
      end else if (!accept_s && pop_s) begin
        fifo_cnt_d = fifo_cnt_q - 1'b1;
      end else begin
        fifo_cnt_d = fifo_cnt_q;
      end
      if (push_s && !accept_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State registers for the input, timestamp and queue path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '{default: '0};
      div_q         <= '0;
      ts_q          <= '0;
      fifo_mem_q    <= '{default: '0};
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      db_cnt_q      <= db_cnt_d;
      div_q         <= div_d;
      ts_q          <= ts_d;
      fifo_mem_q    <= fifo_mem_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  // Writer FSM: one registered Avalon write per popped event, then advance the log pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= '0;
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            wdata_q <= fifo_mem_q[fifo_rd_q];
            addr_q  <= wr_ptr_q;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            be_q    <= 4'hF;
            state_q <= ST_WRITE;
          end
          if (clear) begin
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          be_q    <= 4'h0;
          state_q <= ST_IDLE;
          // The in-flight write finishes at its old address; clear wins over the increment.
          if (clear) begin
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
          end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (&wr_ptr_q) begin
              wrapped_q <= 1'b1;
            end
          end
        end
        default: begin
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          be_q    <= 4'h0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_address    = addr_q;
  assign mem.mem_chipselect = cs_q;
  assign mem.mem_write      = we_q;
  assign mem.mem_byteenable = be_q;
  assign mem.mem_writedata  = wdata_q;
  assign wr_ptr             = wr_ptr_q;
  assign wrapped            = wrapped_q;
  assign overflow           = overflow_q;
endmodule
